dmem_arbiter: RTL and testbench

Shares the single-port data memory between two requesters: port 0 (CPU load/store path) and port 1 (program/data loader or debug port). A three-state sequencer grants one access at a time and drives the memory strobes. It performs byte-lane steering for byte accesses and returns acknowledge, read data and an alignment error to the winning port. It sits between the CPU control/datapath and the DMEM instance.

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: IDLE/ACCESS/RESP sequencer,
// byte-lane steering and alignment checks. Define DMEM_ARB_RR_EN for round-robin arbitration.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        WrEn0,
  input  logic        WrEn1,
  input  logic        Byte0,
  input  logic        Byte1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] WrData0,
  input  logic [31:0] WrData1,
  output logic        Ack0,
  output logic        Ack1,
  output logic        Err0,
  output logic        Err1,
  output logic [31:0] RdData,
  output logic        Busy,
  output logic        MEM_En,
  output logic        MEM_WrEn,
  output logic [31:0] MEM_Addr,
  output logic [3:0]  MEM_ByteEn,
  output logic [31:0] MEM_WrData,
  input  logic [31:0] MEM_RdData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic        sel;
  logic        wr_q;
  logic        byte_q;
  logic        mis_q;
  logic [1:0]  lane_q;

  logic        tie_to_1;
  logic        win;
  logic        win_wr;
  logic        win_byte;
  logic        win_mis;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [3:0]  win_be;
  logic [31:0] win_wd;

`ifdef DMEM_ARB_RR_EN
  logic last;
  assign tie_to_1 = ~last;
`else
  logic [3:0] starve;
  assign tie_to_1 = (starve == 4'(STARVE_MAX));
`endif

  always_comb begin
    win       = Req1 & (~Req0 | tie_to_1);
    win_wr    = win ? WrEn1   : WrEn0;
    win_byte  = win ? Byte1   : Byte0;
    win_addr  = win ? Addr1   : Addr0;
    win_wdata = win ? WrData1 : WrData0;
    win_mis   = ~win_byte & (win_addr[1:0] != 2'b00);
    win_be    = '0;
    win_wd    = '0;
    if (win_wr && !win_mis) begin
      win_be = win_byte ? (4'b0001 << win_addr[1:0]) : 4'b1111;
      win_wd = win_byte ? {4{win_wdata[7:0]}} : win_wdata;
    end
  end

  // Read data comes straight from the synchronous memory during the Ack cycle.
  always_comb begin
    RdData = '0;
    if ((Ack0 || Ack1) && !wr_q && !mis_q)
      RdData = byte_q ? {24'h0, MEM_RdData[{lane_q, 3'b000} +: 8]} : MEM_RdData;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      wr_q       <= 1'b0;
      byte_q     <= 1'b0;
      mis_q      <= 1'b0;
      lane_q     <= '0;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
      Err0       <= 1'b0;
      Err1       <= 1'b0;
      Busy       <= 1'b0;
      MEM_En     <= 1'b0;
      MEM_WrEn   <= 1'b0;
      MEM_Addr   <= '0;
      MEM_ByteEn <= '0;
      MEM_WrData <= '0;
`ifdef DMEM_ARB_RR_EN
      last       <= 1'b1;
`else
      starve     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Req0 || Req1) begin
            state      <= ACCESS;
            sel        <= win;
            wr_q       <= win_wr;
            byte_q     <= win_byte;
            mis_q      <= win_mis;
            lane_q     <= win_addr[1:0];
            Busy       <= 1'b1;
            MEM_En     <= ~win_mis;
            MEM_WrEn   <= win_wr & ~win_mis;
            MEM_Addr   <= win_mis ? '0 : {win_addr[31:2], 2'b00};
            MEM_ByteEn <= win_be;
            MEM_WrData <= win_wd;
`ifdef DMEM_ARB_RR_EN
            last       <= win;
`else
            // Port 1 losing while requesting can only be a lost tie.
            if (win)
              starve <= '0;
            else if (Req1)
              starve <= starve + 4'd1;
`endif
          end
        end
        ACCESS: begin
          state      <= RESP;
          MEM_En     <= 1'b0;
          MEM_WrEn   <= 1'b0;
          MEM_Addr   <= '0;
          MEM_ByteEn <= '0;
          MEM_WrData <= '0;
          Ack0       <= ~sel;
          Ack1       <= sel;
          Err0       <= ~sel & mis_q;
          Err1       <= sel & mis_q;
        end
        RESP: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Ack0  <= 1'b0;
          Ack1  <= 1'b0;
          Err0  <= 1'b0;
          Err1  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level reference model, per-cycle compare,
// directed literal checks and randomized two-port traffic against a behavioural memory.
module tb_dmem_arbiter;
  localparam int unsigned STARVE = 3;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic        WrEn0 = 1'b0, WrEn1 = 1'b0;
  logic        Byte0 = 1'b0, Byte1 = 1'b0;
  logic [31:0] Addr0 = '0, Addr1 = '0;
  logic [31:0] WrData0 = '0, WrData1 = '0;
  logic        Ack0, Ack1, Err0, Err1, Busy, MEM_En, MEM_WrEn;
  logic [31:0] RdData, MEM_Addr, MEM_WrData, MEM_RdData;
  logic [3:0]  MEM_ByteEn;

  dmem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0(Req0), .Req1(Req1), .WrEn0(WrEn0), .WrEn1(WrEn1),
    .Byte0(Byte0), .Byte1(Byte1), .Addr0(Addr0), .Addr1(Addr1),
    .WrData0(WrData0), .WrData1(WrData1),
    .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1),
    .RdData(RdData), .Busy(Busy),
    .MEM_En(MEM_En), .MEM_WrEn(MEM_WrEn), .MEM_Addr(MEM_Addr),
    .MEM_ByteEn(MEM_ByteEn), .MEM_WrData(MEM_WrData), .MEM_RdData(MEM_RdData)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory as seen by the DUT strobes, and the memory the model expects.
  logic [7:0]  dmem [256];
  logic [7:0]  em   [256];
  logic [31:0] mem_rd;
  assign MEM_RdData = mem_rd;

  initial begin
    mem_rd = '0;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 8'h00;
      em[i]   = 8'h00;
    end
    forever begin
      @(posedge Clk);
      if (MEM_En) begin
        if (MEM_WrEn) begin
          for (int b = 0; b < 4; b++)
            if (MEM_ByteEn[b]) dmem[MEM_Addr[7:0] + 8'(b)] = MEM_WrData[8*b +: 8];
        end else begin
          mem_rd = {dmem[MEM_Addr[7:0] + 8'd3], dmem[MEM_Addr[7:0] + 8'd2],
                    dmem[MEM_Addr[7:0] + 8'd1], dmem[MEM_Addr[7:0]]};
        end
      end
    end
  end

  // Transaction-level reference: phase 0 idle, 1 memory cycle, 2 response cycle.
  int          m_ph = 0;
  bit          m_sel = 1'b0, m_wr = 1'b0, m_byte = 1'b0, m_mis = 1'b0;
  logic [31:0] m_addr = '0, m_wd = '0, m_rd = '0;
  logic [7:0]  ea;
`ifdef DMEM_ARB_RR_EN
  bit          m_last = 1'b1;
`else
  int          m_lost = 0;
`endif

  initial forever begin
    @(posedge Clk or negedge Reset_n);
    if (!Reset_n) begin
      m_ph  = 0;
      m_sel = 1'b0;
`ifdef DMEM_ARB_RR_EN
      m_last = 1'b1;
`else
      m_lost = 0;
`endif
    end else if (m_ph == 0) begin
      if (Req0 || Req1) begin
        if (Req0 && Req1) begin
`ifdef DMEM_ARB_RR_EN
          m_sel = !m_last;
`else
          m_sel = (m_lost == int'(STARVE));
`endif
        end else begin
          m_sel = Req1;
        end
`ifdef DMEM_ARB_RR_EN
        m_last = m_sel;
`else
        if (m_sel) m_lost = 0;
        else if (Req1) m_lost++;
`endif
        m_wr   = m_sel ? WrEn1   : WrEn0;
        m_byte = m_sel ? Byte1   : Byte0;
        m_addr = m_sel ? Addr1   : Addr0;
        m_wd   = m_sel ? WrData1 : WrData0;
        m_mis  = !m_byte && (m_addr[1:0] != 2'b00);
        m_ph   = 1;
      end
    end else if (m_ph == 1) begin
      ea = {m_addr[7:2], 2'b00};
      if (!m_mis && m_wr) begin
        if (m_byte) em[m_addr[7:0]] = m_wd[7:0];
        else begin
          em[ea] = m_wd[7:0];           em[ea + 8'd1] = m_wd[15:8];
          em[ea + 8'd2] = m_wd[23:16];  em[ea + 8'd3] = m_wd[31:24];
        end
      end
      if (!m_mis && !m_wr)
        m_rd = m_byte ? {24'h0, em[m_addr[7:0]]}
                      : {em[ea + 8'd3], em[ea + 8'd2], em[ea + 8'd1], em[ea]};
      m_ph = 2;
    end else begin
      m_ph = 0;
    end
  end

  logic        e_ack0, e_ack1, e_err0, e_err1, e_busy, e_en, e_wen;
  logic [31:0] e_addr, e_wd, e_rd;
  logic [3:0]  e_be;

  initial forever begin
    @(negedge Clk);
    {e_ack0, e_ack1, e_err0, e_err1, e_busy, e_en, e_wen} = '0;
    e_addr = '0; e_wd = '0; e_rd = '0; e_be = '0;
    if (m_ph == 1) begin
      e_busy = 1'b1;
      e_en   = !m_mis;
      e_wen  = !m_mis && m_wr;
      if (!m_mis) e_addr = {m_addr[31:2], 2'b00};
      if (e_wen) begin
        e_be = m_byte ? (4'b0001 << m_addr[1:0]) : 4'b1111;
        e_wd = m_byte ? {4{m_wd[7:0]}} : m_wd;
      end
    end else if (m_ph == 2) begin
      e_busy = 1'b1;
      e_ack0 = !m_sel;
      e_ack1 = m_sel;
      e_err0 = !m_sel && m_mis;
      e_err1 = m_sel && m_mis;
      if (!m_mis && !m_wr) e_rd = m_rd;
    end
    chk("cyc_ack_err_busy", 32'({Ack0, Ack1, Err0, Err1, Busy}),
        32'({e_ack0, e_ack1, e_err0, e_err1, e_busy}));
    chk("cyc_mem_en_wr", 32'({MEM_En, MEM_WrEn}), 32'({e_en, e_wen}));
    chk("cyc_mem_addr", MEM_Addr, e_addr);
    chk("cyc_byteen", 32'(MEM_ByteEn), 32'(e_be));
    chk("cyc_wrdata", MEM_WrData, e_wd);
    chk("cyc_rddata", RdData, e_rd);
  end

  // One directed transaction; starts just after a rising edge with the DUT idle.
  task automatic txn(input int p, input bit w, input bit b, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output bit er,
                     output int lat, output logic [3:0] be, output logic [31:0] wd,
                     output bit en);
    rd = '0; er = 1'b0; lat = -1; be = '0; wd = '0; en = 1'b0;
    if (p == 0) begin Req0 = 1'b1; WrEn0 = w; Byte0 = b; Addr0 = a; WrData0 = d; end
    else        begin Req1 = 1'b1; WrEn1 = w; Byte1 = b; Addr1 = a; WrData1 = d; end
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      if (MEM_En) en = 1'b1;
      if (MEM_WrEn) begin be = MEM_ByteEn; wd = MEM_WrData; end
      if ((p == 0 && Ack0) || (p == 1 && Ack1)) begin
        rd  = RdData;
        er  = (p == 1) ? Err1 : Err0;
        lat = i - 1;
        break;
      end
    end
    @(posedge Clk); #1;
    if (p == 0) Req0 = 1'b0; else Req1 = 1'b0;
  endtask

  task automatic drive(input int p, input bit rq);
    logic [31:0] a, d;
    bit w, b;
    a = $urandom & 32'hF000_003F;
    d = $urandom;
    w = 1'($urandom_range(0, 1));
    b = 1'($urandom_range(0, 1));
    if (p == 0) begin Req0 = rq; WrEn0 = w; Byte0 = b; Addr0 = a; WrData0 = d; end
    else        begin Req1 = rq; WrEn1 = w; Byte1 = b; Addr1 = a; WrData1 = d; end
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  logic [31:0] rd, wd;
  logic [3:0]  be;
  bit          er, en, cur;
  int          lat;
  int          order[$];
  int          exp_order[8];

  initial begin
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};
`endif
    #1 Reset_n = 1'b0;
    @(negedge Clk);
    chk("reset_ctrl", 32'({Ack0, Ack1, Err0, Err1, Busy, MEM_En, MEM_WrEn}), 32'h0);
    chk("reset_bus", MEM_Addr | MEM_WrData | RdData | 32'(MEM_ByteEn), 32'h0);
    @(posedge Clk); #1 Reset_n = 1'b1;

    txn(0, 1, 0, 32'h10, 32'hDEADBEEF, rd, er, lat, be, wd, en);
    chk("sw_byteen", 32'(be), 32'h0000_000F);
    chk("sw_latency", 32'(lat), 32'd2);
    txn(0, 0, 0, 32'h10, 32'h0, rd, er, lat, be, wd, en);
    chk("lw_latency", 32'(lat), 32'd2);
    chk("lw_data", rd, 32'hDEADBEEF);
    txn(0, 1, 1, 32'h13, 32'h0000_00A5, rd, er, lat, be, wd, en);
    chk("sb_byteen", 32'(be), 32'h0000_0008);
    chk("sb_wrdata", wd, 32'hA5A5A5A5);
    txn(0, 0, 1, 32'h13, 32'h0, rd, er, lat, be, wd, en);
    chk("lb_data", rd, 32'h0000_00A5);
    txn(0, 0, 0, 32'h10, 32'h0, rd, er, lat, be, wd, en);
    chk("lw_after_sb", rd, 32'hA5ADBEEF);
    txn(0, 0, 0, 32'h06, 32'h0, rd, er, lat, be, wd, en);
    chk("mis_mem_en", 32'(en), 32'h0);
    chk("mis_err", 32'(er), 32'h1);
    chk("mis_rddata", rd, 32'h0);
    chk("mis_latency", 32'(lat), 32'd2);

    // Contention from a fresh reset with both ports held high.
    do_reset();
    WrEn0 = 1'b0; Byte0 = 1'b0; Addr0 = 32'h20;
    WrEn1 = 1'b0; Byte1 = 1'b0; Addr1 = 32'h24;
    Req0 = 1'b1; Req1 = 1'b1;
    for (int c = 0; c < 40 && order.size() < 8; c++) begin
      @(negedge Clk);
      if (Ack0) order.push_back(0);
      if (Ack1) order.push_back(1);
    end
    @(posedge Clk); #1;
    Req0 = 1'b0; Req1 = 1'b0;
    chk("grant_count", 32'(order.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      chk("grant_order", (k < order.size()) ? 32'(order[k]) : 32'hFFFF_FFFF, 32'(exp_order[k]));

    // Reset asserted while a port 1 store is in its memory cycle.
    Req1 = 1'b1; WrEn1 = 1'b1; Byte1 = 1'b0; Addr1 = 32'h30; WrData1 = 32'h12345678;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_pre_wren", 32'(MEM_WrEn), 32'h1);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_async_wren", 32'(MEM_WrEn), 32'h0);
    chk("rst_async_en", 32'(MEM_En), 32'h0);
    Req1 = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1 Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_after_busy", 32'(Busy), 32'h0);
    chk("rst_no_ack1", 32'(Ack1), 32'h0);
    chk("rst_mem_untouched", {dmem[8'h33], dmem[8'h32], dmem[8'h31], dmem[8'h30]}, 32'h0);

    repeat (400) begin
      @(posedge Clk); #1;
      for (int p = 0; p < 2; p++) begin
        cur = (p == 0) ? Req0 : Req1;
        if (m_ph == 1 && int'(m_sel) == p) begin
          case ($urandom_range(0, 2))
            0:       drive(p, 1'b0);
            1:       drive(p, cur);
            default: ;
          endcase
        end else if (m_ph == 2 && int'(m_sel) == p) begin
          drive(p, 1'($urandom_range(0, 1)));
        end else if (!cur && $urandom_range(0, 2) == 0) begin
          drive(p, 1'b1);
        end
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    chk("idle_strobes", 32'({MEM_En, MEM_WrEn, Busy}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
